// File: rtl/wr_sched_pkg.sv
// Shared types for the WR TAI trigger scheduler.
//   TAI_W / CYC_W : widths of the TAI-seconds LSBs and the cycle-in-second counter
//   wr_evt_t      : one queued trigger request (target second + target cycle)
//   sched_state_t : scheduler FSM state encoding
//   evt_is_late   : modular "already past" test between an event and current WR time
package wr_sched_pkg;

  localparam int TAI_W = 10;
  localparam int CYC_W = 27;

  typedef struct packed {
    logic [TAI_W-1:0] tai;
    logic [CYC_W-1:0] cycle;
  } wr_evt_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WAIT  = 2'd2
  } sched_state_t;

  // Seconds difference is taken modulo 2^TAI_W so the compare survives the
  // TAI LSB wrap; anything half a wrap or more "ahead" is really behind us.
  function automatic logic evt_is_late(input logic [TAI_W-1:0] head_tai,
                                       input logic [TAI_W-1:0] now_tai,
                                       input logic [CYC_W-1:0] head_cyc,
                                       input logic [CYC_W-1:0] now_cyc);
    logic [TAI_W-1:0] d;
    d = head_tai - now_tai;
    return d[TAI_W-1] || ((d == '0) && (now_cyc > head_cyc));
  endfunction

endpackage

// File: rtl/wr_sched_fifo.sv
// Synchronous first-word-fall-through FIFO of wr_evt_t.
//   clk_sys_i, rst_i : clock, synchronous active-high reset
//   flush_i          : empties the FIFO (wins over push/pop)
//   push_i, wr_data_i: write side; push ignored when full
//   pop_i, rd_data_o : read side; rd_data_o valid whenever empty_o=0
//   full_o, empty_o  : flags derived from the registered count
//   count_o          : current occupancy
module wr_sched_fifo
  import wr_sched_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk_sys_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  wr_evt_t                  wr_data_i,
  input  logic                     pop_i,
  output wr_evt_t                  rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  wr_evt_t        mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic           do_push;
  logic           do_pop;

  assign full_o    = (count == (AW+1)'(DEPTH));
  assign empty_o   = (count == '0);
  assign count_o   = count;
  assign rd_data_o = mem[rd_ptr];
  assign do_push   = push_i && !full_o;
  assign do_pop    = pop_i && !empty_o;

  always_ff @(posedge clk_sys_i) begin
    if (rst_i || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_sys_i) begin
    if (do_push) mem[wr_ptr] <= wr_data_i;
  end

endmodule

// File: rtl/wr_tai_trigger_scheduler.sv
// Queues host trigger requests stamped in WR time and fires trig_o when the
// local WR time base (pps_i / tm_tai_i) reaches each one; past events are
// dropped and counted.
//   clk_sys_i, rst_i        : WR system clock, synchronous active-high reset
//   pps_i, tm_tai_i         : PPS pulse and TAI seconds from the WR core
//   time_valid_i            : WR time locked; compare is frozen while low
//   req_valid_i/req_ready_o : request handshake; req_tai_i/req_cycle_i target
//   flush_i                 : drop everything queued/armed, cut the pulse
//   trig_o, late_o          : trigger pulse, 1-cycle late-drop indication
//   fill_o, armed_o         : FIFO occupancy, head event armed
//   cyc_cnt_o               : cycles since last PPS
//   fire_count_o            : fired events (wraps)
//   late_count_o            : late drops (saturates)
//
// state    | meaning
// ST_EMPTY | nothing armed, waiting for the FIFO to hold an event
// ST_LOAD  | popping the FIFO head into the head registers
// ST_WAIT  | head armed, comparing against WR time
module wr_tai_trigger_scheduler
  import wr_sched_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int PULSE_LEN = 4
) (
  input  logic                     clk_sys_i,
  input  logic                     rst_i,
  input  logic                     pps_i,
  input  logic [TAI_W-1:0]         tm_tai_i,
  input  logic                     time_valid_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [TAI_W-1:0]         req_tai_i,
  input  logic [CYC_W-1:0]         req_cycle_i,
  input  logic                     flush_i,
  output logic                     trig_o,
  output logic                     late_o,
  output logic [$clog2(DEPTH):0]   fill_o,
  output logic                     armed_o,
  output logic [CYC_W-1:0]         cyc_cnt_o,
  output logic [31:0]              fire_count_o,
  output logic [15:0]              late_count_o
);

  localparam logic [7:0] PULSE_INIT = 8'(PULSE_LEN);

  logic [CYC_W-1:0] cyc_cnt;
  logic [TAI_W-1:0] tai_q;
  sched_state_t     state, state_d;
  wr_evt_t          head, fifo_rd, req_evt;
  logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic             match, late_hit, fire, drop;
  logic [7:0]       pulse_cnt;
  logic             late_q;
  logic [31:0]      fire_cnt;
  logic [15:0]      late_cnt;

  assign req_ready_o  = !fifo_full;
  assign fifo_push    = req_valid_i && !fifo_full && !flush_i;
  assign req_evt      = '{tai: req_tai_i, cycle: req_cycle_i};
  assign trig_o       = (pulse_cnt != '0);
  assign late_o       = late_q;
  assign armed_o      = (state == ST_WAIT);
  assign cyc_cnt_o    = cyc_cnt;
  assign fire_count_o = fire_cnt;
  assign late_count_o = late_cnt;

  wr_sched_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_sys_i (clk_sys_i),
    .rst_i     (rst_i),
    .flush_i   (flush_i),
    .push_i    (fifo_push),
    .wr_data_i (req_evt),
    .pop_i     (fifo_pop),
    .rd_data_o (fifo_rd),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fill_o)
  );

  // Time base; the counter saturates so a missing PPS never aliases to an early cycle.
  always_ff @(posedge clk_sys_i) begin
    if (rst_i) begin
      cyc_cnt <= '0;
      tai_q   <= '0;
    end else if (pps_i) begin
      cyc_cnt <= '0;
      tai_q   <= tm_tai_i;
    end else if (cyc_cnt != '1) begin
      cyc_cnt <= cyc_cnt + CYC_W'(1);
    end
  end

  assign match    = (tai_q == head.tai) && (cyc_cnt == head.cycle);
  assign late_hit = evt_is_late(head.tai, tai_q, head.cycle, cyc_cnt);

  always_ff @(posedge clk_sys_i) begin
    if (rst_i) state <= ST_EMPTY;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_EMPTY: if (!fifo_empty) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_WAIT;
      ST_WAIT:  if (time_valid_i && (match || late_hit))
                  state_d = fifo_empty ? ST_EMPTY : ST_LOAD;
      default:  state_d = ST_EMPTY;
    endcase
    if (flush_i) state_d = ST_EMPTY;
  end

  always_comb begin
    fifo_pop = (state == ST_LOAD) && !flush_i;
    fire     = (state == ST_WAIT) && time_valid_i && match && !flush_i;
    drop     = (state == ST_WAIT) && time_valid_i && !match && late_hit && !flush_i;
  end

  always_ff @(posedge clk_sys_i) begin
    if (rst_i)         head <= '0;
    else if (fifo_pop) head <= fifo_rd;
  end

  // A fire during a running pulse reloads the length, extending it without a gap.
  always_ff @(posedge clk_sys_i) begin
    if (rst_i || flush_i)     pulse_cnt <= '0;
    else if (fire)            pulse_cnt <= PULSE_INIT;
    else if (pulse_cnt != '0) pulse_cnt <= pulse_cnt - 8'd1;
  end

  always_ff @(posedge clk_sys_i) begin
    if (rst_i) begin
      late_q   <= 1'b0;
      fire_cnt <= '0;
      late_cnt <= '0;
    end else begin
      late_q <= drop;
      if (fire) fire_cnt <= fire_cnt + 32'd1;
      if (drop && (late_cnt != '1)) late_cnt <= late_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_wr_tai_trigger_scheduler.sv
module tb_wr_tai_trigger_scheduler;
  import wr_sched_pkg::*;

  logic              clk_sys_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              pps_i = 1'b0;
  logic [TAI_W-1:0]  tm_tai_i = '0;
  logic              time_valid_i = 1'b1;
  logic              req_valid_i = 1'b0;
  logic              req_ready_o;
  logic [TAI_W-1:0]  req_tai_i = '0;
  logic [CYC_W-1:0]  req_cycle_i = '0;
  logic              flush_i = 1'b0;
  logic              trig_o;
  logic              late_o;
  logic [3:0]        fill_o;
  logic              armed_o;
  logic [CYC_W-1:0]  cyc_cnt_o;
  logic [31:0]       fire_count_o;
  logic [15:0]       late_count_o;

  always #4 clk_sys_i = ~clk_sys_i;

  wr_tai_trigger_scheduler #(.DEPTH(8), .PULSE_LEN(4)) dut (
    .clk_sys_i    (clk_sys_i),
    .rst_i        (rst_i),
    .pps_i        (pps_i),
    .tm_tai_i     (tm_tai_i),
    .time_valid_i (time_valid_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_tai_i    (req_tai_i),
    .req_cycle_i  (req_cycle_i),
    .flush_i      (flush_i),
    .trig_o       (trig_o),
    .late_o       (late_o),
    .fill_o       (fill_o),
    .armed_o      (armed_o),
    .cyc_cnt_o    (cyc_cnt_o),
    .fire_count_o (fire_count_o),
    .late_count_o (late_count_o)
  );

  // is_fire=1: trig_o rising edge, cyc = cyc_cnt_o at the first high cycle,
  // len = high cycles. is_fire=0: late_o pulse, cyc=-1 means don't care.
  typedef struct {
    bit is_fire;
    int cyc;
    int len;
  } evt_rec_t;

  evt_rec_t exp_q[$];
  evt_rec_t obs_q[$];
  int checks = 0;
  int failures = 0;
  logic trig_d = 1'b0;

  always @(negedge clk_sys_i) begin
    if (trig_o && !trig_d) obs_q.push_back('{is_fire: 1'b1, cyc: int'(cyc_cnt_o), len: 0});
    if (late_o)            obs_q.push_back('{is_fire: 1'b0, cyc: int'(cyc_cnt_o), len: 0});
    trig_d = trig_o;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // All drivers run in the posedge+1 phase.
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_sys_i);
    #1;
  endtask

  task automatic do_pps(input logic [TAI_W-1:0] t);
    pps_i = 1'b1;
    tm_tai_i = t;
    tick();
    pps_i = 1'b0;
  endtask

  task automatic push_req(input logic [TAI_W-1:0] t, input int c, output bit acc);
    req_valid_i = 1'b1;
    req_tai_i = t;
    req_cycle_i = CYC_W'(c);
    acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) begin
      acc = req_ready_o;
      tick();
    end
    req_valid_i = 1'b0;
  endtask

  task automatic wait_obs(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (obs_q.size() != 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_sys_i);
      #1;
    end
    if (obs_q.size() != 0) ok = 1'b1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick(3);
    checks++;
    if ({trig_o, late_o, armed_o} !== 3'b000 || req_ready_o !== 1'b1 || fill_o !== 4'd0 ||
        cyc_cnt_o !== '0 || fire_count_o !== 32'd0 || late_count_o !== 16'd0) begin
      failures++;
      $display("FAIL reset_state: trig=%b late=%b armed=%b ready=%b fill=%0d cyc=%0d fire=%0d late_cnt=%0d, required 0 0 0 1 0 0 0 0",
               trig_o, late_o, armed_o, req_ready_o, fill_o, cyc_cnt_o, fire_count_o, late_count_o);
    end
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_fire();
    bit acc, ok;
    evt_rec_t o, e;
    int len;
    push_req(10'd5, 1000, acc);
    exp_q.push_back('{is_fire: 1'b1, cyc: 1001, len: 4});
    tick(5);
    checks++;
    if (armed_o !== 1'b1 || !acc) begin
      failures++;
      $display("FAIL fire_armed: armed=%b accepted=%b, required 1 1", armed_o, acc);
    end
    do_pps(10'd5);
    wait_obs(1100, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL fire_timeout: no output event, required trig at cyc 1001");
    end else begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      len = 0;
      for (int i = 0; i < 20 && trig_o; i++) begin
        len++;
        @(negedge clk_sys_i);
        #1;
      end
      if (o.is_fire !== e.is_fire || o.cyc != e.cyc || len != e.len) begin
        failures++;
        $display("FAIL fire_event: fire=%0d cyc=%0d len=%0d, required fire=%0d cyc=%0d len=%0d",
                 o.is_fire, o.cyc, len, e.is_fire, e.cyc, e.len);
      end
    end
    tick();
    checks++;
    if (fire_count_o !== 32'd1 || late_count_o !== 16'd0) begin
      failures++;
      $display("FAIL fire_count: fire=%0d late=%0d, required 1 0", fire_count_o, late_count_o);
    end
  endtask

  task automatic test_late();
    bit acc, ok;
    evt_rec_t o, e;
    push_req(10'd4, 0, acc);
    exp_q.push_back('{is_fire: 1'b0, cyc: -1, len: 0});
    wait_obs(50, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL late_timeout: no output event, required late pulse");
    end else begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      if (o.is_fire !== e.is_fire) begin
        failures++;
        $display("FAIL late_event: fire=%0d, required fire=%0d", o.is_fire, e.is_fire);
      end
    end
    tick(3);
    checks++;
    if (late_count_o !== 16'd1 || fire_count_o !== 32'd1 || trig_o !== 1'b0 || armed_o !== 1'b0) begin
      failures++;
      $display("FAIL late_count: late=%0d fire=%0d trig=%b armed=%b, required 1 1 0 0",
               late_count_o, fire_count_o, trig_o, armed_o);
    end
  endtask

  task automatic test_wrap();
    bit acc, ok;
    evt_rec_t o, e;
    int len;
    do_pps(10'd1023);
    tick(3);
    push_req(10'd1, 10, acc);
    exp_q.push_back('{is_fire: 1'b1, cyc: 11, len: 4});
    tick(5);
    do_pps(10'd0);
    tick(20);
    checks++;
    if (armed_o !== 1'b1 || obs_q.size() != 0 || late_count_o !== 16'd1) begin
      failures++;
      $display("FAIL wrap_hold: armed=%b obs=%0d late=%0d, required 1 0 1", armed_o, obs_q.size(), late_count_o);
    end
    do_pps(10'd1);
    wait_obs(100, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL wrap_timeout: no output event, required trig at cyc 11");
    end else begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      len = 0;
      for (int i = 0; i < 20 && trig_o; i++) begin
        len++;
        @(negedge clk_sys_i);
        #1;
      end
      if (o.is_fire !== e.is_fire || o.cyc != e.cyc || len != e.len) begin
        failures++;
        $display("FAIL wrap_event: fire=%0d cyc=%0d len=%0d, required fire=%0d cyc=%0d len=%0d",
                 o.is_fire, o.cyc, len, e.is_fire, e.cyc, e.len);
      end
    end
    tick();
    checks++;
    if (fire_count_o !== 32'd2) begin
      failures++;
      $display("FAIL wrap_count: fire=%0d, required 2", fire_count_o);
    end
  endtask

  task automatic test_back_to_back();
    bit acc, ok;
    evt_rec_t o, e;
    int len;
    do_pps(10'd7);
    push_req(10'd7, 100, acc);
    push_req(10'd7, 101, acc);
    exp_q.push_back('{is_fire: 1'b1, cyc: 101, len: 4});
    exp_q.push_back('{is_fire: 1'b0, cyc: 103, len: 0});
    for (int k = 0; k < 2; k++) begin
      wait_obs(200, ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL b2b_close_timeout: event %0d missing", k);
      end else begin
        o = obs_q.pop_front();
        e = exp_q.pop_front();
        len = 0;
        if (o.is_fire) begin
          for (int i = 0; i < 20 && trig_o; i++) begin
            len++;
            @(negedge clk_sys_i);
            #1;
          end
        end
        if (o.is_fire !== e.is_fire || o.cyc != e.cyc || len != e.len) begin
          failures++;
          $display("FAIL b2b_close_event: fire=%0d cyc=%0d len=%0d, required fire=%0d cyc=%0d len=%0d",
                   o.is_fire, o.cyc, len, e.is_fire, e.cyc, e.len);
        end
      end
    end
    tick();
    do_pps(10'd8);
    push_req(10'd8, 100, acc);
    push_req(10'd8, 102, acc);
    exp_q.push_back('{is_fire: 1'b1, cyc: 101, len: 6});
    wait_obs(200, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL b2b_ext_timeout: no output event");
    end else begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      len = 0;
      for (int i = 0; i < 20 && trig_o; i++) begin
        len++;
        @(negedge clk_sys_i);
        #1;
      end
      if (o.is_fire !== e.is_fire || o.cyc != e.cyc || len != e.len) begin
        failures++;
        $display("FAIL b2b_ext_event: fire=%0d cyc=%0d len=%0d, required fire=%0d cyc=%0d len=%0d",
                 o.is_fire, o.cyc, len, e.is_fire, e.cyc, e.len);
      end
    end
    tick();
    checks++;
    if (fire_count_o !== 32'd5 || late_count_o !== 16'd2 || obs_q.size() != 0) begin
      failures++;
      $display("FAIL b2b_count: fire=%0d late=%0d obs=%0d, required 5 2 0", fire_count_o, late_count_o, obs_q.size());
    end
  endtask

  task automatic test_invalid();
    bit acc, ok;
    evt_rec_t o, e;
    time_valid_i = 1'b0;
    do_pps(10'd9);
    push_req(10'd9, 50, acc);
    exp_q.push_back('{is_fire: 1'b0, cyc: -1, len: 0});
    tick(80);
    checks++;
    if (armed_o !== 1'b1 || obs_q.size() != 0 || late_count_o !== 16'd2 || trig_o !== 1'b0) begin
      failures++;
      $display("FAIL invalid_hold: armed=%b obs=%0d late=%0d trig=%b, required 1 0 2 0",
               armed_o, obs_q.size(), late_count_o, trig_o);
    end
    time_valid_i = 1'b1;
    wait_obs(20, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL invalid_timeout: no late pulse after time_valid returned");
    end else begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      if (o.is_fire !== e.is_fire) begin
        failures++;
        $display("FAIL invalid_event: fire=%0d, required fire=%0d", o.is_fire, e.is_fire);
      end
    end
    tick(2);
    checks++;
    if (late_count_o !== 16'd3 || fire_count_o !== 32'd5) begin
      failures++;
      $display("FAIL invalid_count: late=%0d fire=%0d, required 3 5", late_count_o, fire_count_o);
    end
  endtask

  task automatic test_full();
    bit acc;
    int n_acc;
    time_valid_i = 1'b0;
    push_req(10'd12, 0, acc);
    tick(4);
    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      push_req(10'd12, i + 1, acc);
      if (acc) n_acc++;
    end
    checks++;
    if (n_acc != 8 || fill_o !== 4'd8 || req_ready_o !== 1'b0 || armed_o !== 1'b1) begin
      failures++;
      $display("FAIL full_state: accepted=%0d fill=%0d ready=%b armed=%b, required 8 8 0 1",
               n_acc, fill_o, req_ready_o, armed_o);
    end
    req_valid_i = 1'b1;
    req_tai_i = 10'd12;
    req_cycle_i = CYC_W'(99);
    tick(4);
    checks++;
    if (fill_o !== 4'd8 || req_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL full_ninth_blocked: fill=%0d ready=%b, required 8 0", fill_o, req_ready_o);
    end
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    req_valid_i = 1'b0;
    checks++;
    if (fill_o !== 4'd0 || armed_o !== 1'b0 || req_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL full_flush: fill=%0d armed=%b ready=%b, required 0 0 1", fill_o, armed_o, req_ready_o);
    end
    req_valid_i = 1'b1;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    req_valid_i = 1'b0;
    tick(3);
    checks++;
    if (fill_o !== 4'd0 || armed_o !== 1'b0) begin
      failures++;
      $display("FAIL flush_blocks_accept: fill=%0d armed=%b, required 0 0", fill_o, armed_o);
    end
    time_valid_i = 1'b1;
  endtask

  task automatic test_flush();
    bit acc, ok;
    evt_rec_t o, e;
    do_pps(10'd13);
    push_req(10'd13, 30, acc);
    push_req(10'd13, 500, acc);
    exp_q.push_back('{is_fire: 1'b1, cyc: 31, len: 1});
    wait_obs(100, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL flush_fire_timeout: no trig at cyc 31");
    end else begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      if (o.is_fire !== e.is_fire || o.cyc != e.cyc || trig_o !== 1'b0 || fill_o !== 4'd0 || armed_o !== 1'b0) begin
        failures++;
        $display("FAIL flush_cut: fire=%0d cyc=%0d trig=%b fill=%0d armed=%b, required fire=%0d cyc=%0d trig=0 fill=0 armed=0",
                 o.is_fire, o.cyc, trig_o, fill_o, armed_o, e.is_fire, e.cyc);
      end
    end
    tick(520);
    checks++;
    if (obs_q.size() != 0 || fire_count_o !== 32'd6 || late_count_o !== 16'd3) begin
      failures++;
      $display("FAIL flush_retain: obs=%0d fire=%0d late=%0d, required 0 6 3", obs_q.size(), fire_count_o, late_count_o);
    end
  endtask

  task automatic test_reset_mid();
    bit acc;
    push_req(10'd13, 2000, acc);
    push_req(10'd13, 2100, acc);
    tick(4);
    rst_i = 1'b1;
    tick();
    checks++;
    if (armed_o !== 1'b0 || fill_o !== 4'd0 || trig_o !== 1'b0 || cyc_cnt_o !== '0 ||
        fire_count_o !== 32'd0 || late_count_o !== 16'd0) begin
      failures++;
      $display("FAIL reset_mid: armed=%b fill=%0d trig=%b cyc=%0d fire=%0d late=%0d, required all 0",
               armed_o, fill_o, trig_o, cyc_cnt_o, fire_count_o, late_count_o);
    end
    rst_i = 1'b0;
    tick(2);
  endtask

  initial begin
    tick();
    test_reset();
    test_fire();
    test_late();
    test_wrap();
    test_back_to_back();
    test_invalid();
    test_full();
    test_flush();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: expected left=%0d observed left=%0d, required 0 0", exp_q.size(), obs_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
